// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Hunts a serial bit stream for a sync pattern, then collects a WIDTH-bit
//   word (LSB first) plus an optional even-parity bit, and presents the word
//   on a one-entry valid/ready output buffer.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   din         serial data bit
//   din_en      din is sampled only on edges where din_en=1
//   data_out    received word, bit 0 = first data bit received
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer accepts when data_valid & data_ready
//   parity_err  parity result for the word in data_out (0 without parity)
//   overrun     one-cycle pulse when a completed word is dropped
//   locked      1 while in DATA or PAR
module serial_word_receiver #(
  parameter int                  WIDTH     = 8,
  parameter int                  SYNC_LEN  = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT  = 4'b1011,
  parameter bit                  PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             overrun,
  output logic             locked
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = $clog2(SYNC_LEN + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Even parity over word plus parity bit; 1 means the check failed.
  function automatic logic parity_fail(input logic [WIDTH-1:0] w, input logic b);
    return ^{w, b};
  endfunction

  state_t              state_r, state_next_s;
  logic [SYNC_LEN-1:0] sync_r, sync_next_s, sync_shift_s;
  logic [SYNC_LEN:0]   sync_ext_s;
  logic [FW-1:0]       fill_r, fill_next_s;
  logic [CW-1:0]       cnt_r, cnt_next_s;
  logic [WIDTH-1:0]    word_r, word_next_s;
  logic                done_s, done_perr_s, accept_s;

  logic [WIDTH-1:0]    data_out_r;
  logic                data_valid_r, parity_err_r, overrun_r, locked_r;

  assign sync_ext_s   = {sync_r, din};
  assign sync_shift_s = sync_ext_s[SYNC_LEN-1:0];
  assign accept_s     = data_valid_r & data_ready;

  // Next-state, word assembly and word-complete detection.
  always_comb begin
    state_next_s = state_r;
    sync_next_s  = sync_r;
    fill_next_s  = fill_r;
    cnt_next_s   = cnt_r;
    word_next_s  = word_r;
    done_s       = 1'b0;
    done_perr_s  = 1'b0;
    case (state_r)
      HUNT: begin
        if (din_en) begin
          sync_next_s = sync_shift_s;
          // fill_r counts fresh bits since HUNT entry, so a cleared register
          // can never fake a match against a pattern containing zeros.
          if (fill_r != FW'(SYNC_LEN)) begin
            fill_next_s = fill_r + FW'(1);
          end else begin
            fill_next_s = fill_r;
          end
          if ((fill_r >= FW'(SYNC_LEN - 1)) && (sync_shift_s == SYNC_PAT)) begin
            state_next_s = DATA;
            cnt_next_s   = {CW{1'b0}};
          end else begin
            state_next_s = HUNT;
          end
        end else begin
          state_next_s = HUNT;
        end
      end
      DATA: begin
        if (din_en) begin
          word_next_s[cnt_r] = din;
          if (cnt_r == CW'(WIDTH - 1)) begin
            cnt_next_s = {CW{1'b0}};
            if (PARITY_EN) begin
              state_next_s = PAR;
            end else begin
              done_s       = 1'b1;
              state_next_s = HUNT;
              sync_next_s  = {SYNC_LEN{1'b0}};
              fill_next_s  = {FW{1'b0}};
            end
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PAR: begin
        if (din_en) begin
          done_s       = 1'b1;
          done_perr_s  = parity_fail(word_r, din);
          state_next_s = HUNT;
          sync_next_s  = {SYNC_LEN{1'b0}};
          fill_next_s  = {FW{1'b0}};
        end else begin
          state_next_s = PAR;
        end
      end
      default: begin
        state_next_s = HUNT;
        sync_next_s  = {SYNC_LEN{1'b0}};
        fill_next_s  = {FW{1'b0}};
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM, shift register, counters and the word being assembled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
      sync_r  <= {SYNC_LEN{1'b0}};
      fill_r  <= {FW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      word_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      sync_r  <= sync_next_s;
      fill_r  <= fill_next_s;
      cnt_r   <= cnt_next_s;
      word_r  <= word_next_s;
    end
  end

  // One-entry output buffer: a finishing word loads if the slot is empty or
  // being drained this cycle; otherwise it is dropped and overrun pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r   <= {WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      locked_r <= (state_next_s != HUNT);
      if (done_s) begin
        if (!data_valid_r || accept_s) begin
          data_out_r   <= word_next_s;
          parity_err_r <= done_perr_s;
          data_valid_r <= 1'b1;
          overrun_r    <= 1'b0;
        end else begin
          overrun_r <= 1'b1;
        end
      end else begin
        overrun_r <= 1'b0;
        if (accept_s) begin
          data_valid_r <= 1'b0;
        end
      end
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Testbench for serial_word_receiver: directed frame table, hand-written
// overrun / same-edge accept / mid-word reset sequences, and random traffic,
// all compared every cycle against a queue-based reference model.
module tb_serial_word_receiver;

  localparam int         WIDTH     = 8;
  localparam int         SYNC_LEN  = 4;
  localparam logic [3:0] SYNC_PAT  = 4'b1011;
  localparam bit         PARITY_EN = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_en = 1'b0;
  logic             data_ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid, parity_err, overrun, locked;

  int vectors = 0;
  int miscompares = 0;
  logic rdy_g = 1'b0;

  serial_word_receiver #(
    .WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .SYNC_PAT(SYNC_PAT), .PARITY_EN(PARITY_EN)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .overrun(overrun), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: bit history since HUNT entry and bits collected since sync
  bit               m_hunting = 1'b1;
  bit               m_hist[$];
  bit               m_bits[$];
  logic             m_valid = 1'b0, m_perr = 1'b0, m_ovr = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  task automatic model_step(input logic d, input logic e, input logic r, input logic rs);
    bit               done;
    logic [WIDTH-1:0] w;
    logic             pe;
    int               ones;
    int               pat;
    done = 0; w = '0; pe = 1'b0;
    if (rs) begin
      m_hunting = 1; m_hist.delete(); m_bits.delete();
      m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; m_data = '0;
      return;
    end
    if (e) begin
      if (m_hunting) begin
        m_hist.push_back(d);
        if (m_hist.size() > SYNC_LEN) void'(m_hist.pop_front());
        if (m_hist.size() == SYNC_LEN) begin
          pat = 0;
          foreach (m_hist[k]) pat = pat * 2 + int'(m_hist[k]);
          if (pat == int'(SYNC_PAT)) begin
            m_hunting = 0; m_hist.delete(); m_bits.delete();
          end
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == WIDTH + int'(PARITY_EN)) begin
          ones = 0;
          foreach (m_bits[k]) begin
            ones += int'(m_bits[k]);
            if (k < WIDTH) w[k] = m_bits[k];
          end
          pe = PARITY_EN ? logic'(ones % 2) : 1'b0;
          done = 1; m_hunting = 1; m_bits.delete();
        end
      end
    end
    m_ovr = 1'b0;
    if (done) begin
      if (!m_valid || r) begin
        m_data = w; m_perr = pe; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge
  task automatic step(input logic d, input logic e, input logic r, input logic rs);
    din = d; din_en = e; data_ready = r; rst = rs;
    model_step(d, e, m_valid ? r : 1'b0, rs);
    @(posedge clk);
    #1;
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("data_out",   32'(data_out),   32'(m_data));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("locked",     32'(locked),     32'(!m_hunting));
  endtask

  task automatic send_bit(input logic b, input logic r, input bit jitter);
    if (jitter) begin
      repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b0, rdy_g, 1'b0);
    end
    step(b, 1'b1, r, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] pre, input int pre_len, input logic [7:0] w,
                            input logic p, input logic ready_last, input bit jitter);
    for (int i = 0; i < pre_len; i++) send_bit(pre[pre_len-1-i], rdy_g, jitter);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], rdy_g, jitter);
    send_bit(p, ready_last, jitter);
  endtask

  typedef struct {
    logic [7:0] pre;
    int         pre_len;
    logic [7:0] word;
    logic       par;
    logic [7:0] exp_data;
    logic       exp_perr;
  } frame_vec_t;

  frame_vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h0B, 4, 8'h5A, 1'b0, 8'h5A, 1'b0};
    tbl[1] = '{8'h0B, 4, 8'h5A, 1'b1, 8'h5A, 1'b1};
    tbl[2] = '{8'h6B, 7, 8'hC3, 1'b0, 8'hC3, 1'b0};
    tbl[3] = '{8'h0B, 4, 8'hFF, 1'b0, 8'hFF, 1'b0};
    tbl[4] = '{8'h0B, 4, 8'h01, 1'b0, 8'h01, 1'b1};
    tbl[5] = '{8'h0B, 4, 8'h80, 1'b1, 8'h80, 1'b0};

    // reset for two clocks
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);

    // table-driven frames
    rdy_g = 1'b0;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].pre_len; k++) send_bit(tbl[i].pre[tbl[i].pre_len-1-k], 1'b0, 1'b0);
      chk("tbl_locked_after_sync", 32'(locked), 32'h1);
      for (int k = 0; k < WIDTH; k++) send_bit(tbl[i].word[k], 1'b0, 1'b0);
      chk("tbl_valid_before_par", 32'(data_valid), 32'h0);
      send_bit(tbl[i].par, 1'b0, 1'b0);
      chk("tbl_valid", 32'(data_valid), 32'h1);
      chk("tbl_data", 32'(data_out), 32'(tbl[i].exp_data));
      chk("tbl_perr", 32'(parity_err), 32'(tbl[i].exp_perr));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("tbl_drained", 32'(data_valid), 32'h0);
    end

    // overrun: two frames with no consumer
    rdy_g = 1'b0;
    send_frame(8'h0B, 4, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0B, 4, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_keep_old", 32'(data_out), 32'h11);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_one_cycle", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_drain", 32'(data_valid), 32'h0);

    // final bit of frame 2 coincides with the accept of frame 1
    send_frame(8'h0B, 4, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0B, 4, 8'h22, 1'b0, 1'b1, 1'b0);
    chk("same_edge_valid", 32'(data_valid), 32'h1);
    chk("same_edge_data", 32'(data_out), 32'h22);
    chk("same_edge_ovr", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // stalls mid-frame then reset during DATA
    send_frame(8'h0B, 4, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("jitter_data", 32'(data_out), 32'h5A);
    for (int k = 0; k < SYNC_LEN; k++) send_bit(SYNC_PAT[SYNC_LEN-1-k], 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("mid_locked", 32'(locked), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    send_frame(8'h0B, 4, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", 32'(data_out), 32'h3C);
    chk("post_rst_perr", 32'(parity_err), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
